// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the cellular-RAM controller port between the VGA pixel
// fetch path (high priority, reads only) and the user/button path (reads and
// writes). One access is outstanding at a time. A streak counter stops VGA
// from starving a waiting user request. A watchdog aborts accesses the RAM
// never completes.
module mem_arbiter #(
    parameter int ADDR_W        = 26,
    parameter int DATA_W        = 16,
    parameter int MAX_VGA_BURST = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_err,
    input  logic              usr_req,
    input  logic              usr_we,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [DATA_W-1:0] usr_wdata,
    output logic              usr_gnt,
    output logic              usr_valid,
    output logic [DATA_W-1:0] usr_rdata,
    output logic              usr_err,
    output logic              mem_go,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              busy
);

    // Streak counter must hold MAX_VGA_BURST and is never narrower than 3 bits.
    localparam int SW_RAW = $clog2(MAX_VGA_BURST + 1);
    localparam int SW     = (SW_RAW < 3) ? 3 : SW_RAW;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_VGA_BURST);
    localparam logic [7:0]    WDOG_MAX   = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state;
    logic            owner_usr;
    logic [SW-1:0]   streak;
    logic [7:0]      wdog;
    logic            grant_vga;
    logic            grant_usr;
    logic [DATA_W-1:0] done_data;

    // Arbitration decision, only acted upon in IDLE: VGA wins a tie unless
    // it has already taken MAX_VGA_BURST grants while the user was waiting.
    always_comb begin
        grant_vga = 1'b0;
        grant_usr = 1'b0;
        if (vga_req && usr_req) begin
            if (streak == STREAK_MAX) begin
                grant_usr = 1'b1;
            end else begin
                grant_vga = 1'b1;
            end
        end else if (vga_req) begin
            grant_vga = 1'b1;
        end else if (usr_req) begin
            grant_usr = 1'b1;
        end
    end

    // Completed writes return zero rather than whatever the RAM bus carries.
    always_comb begin
        done_data = mem_we ? '0 : mem_rdata;
    end

    // Access sequencer: IDLE grants, ISSUE drops the go strobe and arms the
    // watchdog, WAIT returns data (or an error on timeout) to the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            owner_usr <= 1'b0;
            streak    <= '0;
            wdog      <= '0;
            vga_gnt   <= 1'b0;
            vga_valid <= 1'b0;
            vga_rdata <= '0;
            vga_err   <= 1'b0;
            usr_gnt   <= 1'b0;
            usr_valid <= 1'b0;
            usr_rdata <= '0;
            usr_err   <= 1'b0;
            mem_go    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            vga_gnt   <= 1'b0;
            usr_gnt   <= 1'b0;
            vga_valid <= 1'b0;
            usr_valid <= 1'b0;
            vga_err   <= 1'b0;
            usr_err   <= 1'b0;
            mem_go    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!usr_req || grant_usr) begin
                        streak <= '0;
                    end else if (grant_vga && streak != STREAK_MAX) begin
                        streak <= streak + 1'b1;
                    end

                    if (grant_vga) begin
                        owner_usr <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= vga_addr;
                        vga_gnt   <= 1'b1;
                        mem_go    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end else if (grant_usr) begin
                        owner_usr <= 1'b1;
                        mem_we    <= usr_we;
                        mem_addr  <= usr_addr;
                        mem_wdata <= usr_wdata;
                        usr_gnt   <= 1'b1;
                        mem_go    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (mem_done) begin
                        if (owner_usr) begin
                            usr_rdata <= done_data;
                            usr_valid <= 1'b1;
                        end else begin
                            vga_rdata <= done_data;
                            vga_valid <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (wdog == WDOG_MAX) begin
                        if (owner_usr) begin
                            usr_rdata <= '0;
                            usr_valid <= 1'b1;
                            usr_err   <= 1'b1;
                        end else begin
                            vga_rdata <= '0;
                            vga_valid <= 1'b1;
                            vga_err   <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
